// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared definitions for the fetch-side PC sequencer.
//               Datapath width, reset/trap vectors, the 2-bit FSM encodings
//               and a small alignment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

  localparam int c_WORDSIZE = 32;

  localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] c_TRAP_VECTOR  = 32'h0000_0100;

  // FSM state encoding, kept as plain 2-bit constants for legacy compatibility
  typedef logic [1:0] pcs_state_t;

  localparam pcs_state_t c_PCS_RESET = 2'd0;
  localparam pcs_state_t c_PCS_FETCH = 2'd1;
  localparam pcs_state_t c_PCS_HOLD  = 2'd2;

  // A redirect target is word-misaligned when either of its two LSBs is set
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_incpc.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_incpc
// Description : Sequential PC incrementer (pc + 4, modulo 2^WIDTH).
//               The top address wraps to zero with no carry flag.
// Ports       : pc      in  WIDTH  current program counter
//               pc_inc  out WIDTH  pc + 4
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer_incpc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc
);

  assign pc_inc = pc + WIDTH'(4);

endmodule : pc_sequencer_incpc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-side PC controller. Owns the program counter, issues
//               word fetches over a req/ack handshake, buffers one fetched
//               instruction for decode and applies branch/trap redirects,
//               squashing a fetch that is already in flight.
// Ports       : CLK, RST                 clock / synchronous active-high reset
//               imem_req, imem_addr      fetch request and address (out)
//               imem_ack, imem_rdata     fetch completion and data (in)
//               inst_valid, inst_ready   instruction buffer handshake
//               inst_out, inst_pc        buffered instruction and its address
//               br_taken, br_target      redirect from execute
//               trap_req                 redirect to TRAP_VECTOR
//               misalign                 pulse: branch target misaligned
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                   WORDSIZE     = c_WORDSIZE,
  parameter logic [WORDSIZE-1:0]  RESET_VECTOR = WORDSIZE'(c_RESET_VECTOR),
  parameter logic [WORDSIZE-1:0]  TRAP_VECTOR  = WORDSIZE'(c_TRAP_VECTOR)
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                imem_req,
  output logic [WORDSIZE-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORDSIZE-1:0] imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [WORDSIZE-1:0] inst_out,
  output logic [WORDSIZE-1:0] inst_pc,
  input  logic                br_taken,
  input  logic [WORDSIZE-1:0] br_target,
  input  logic                trap_req,
  output logic                misalign
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  pcs_state_t          r_state;
  logic [WORDSIZE-1:0] r_pc;
  logic [WORDSIZE-1:0] r_redir_pc;     // redirect target held while squashing
  logic                r_squash;       // in-flight fetch must be discarded
  logic                r_pending;      // one idle cycle after a squashed ack
  logic                r_inst_valid;
  logic [WORDSIZE-1:0] r_inst_out;
  logic [WORDSIZE-1:0] r_inst_pc;
  logic                r_misalign;

  // --------------------------------------------------------------------------
  // Combinational next-state / next-pc
  // --------------------------------------------------------------------------
  pcs_state_t          w_state_nxt;
  logic [WORDSIZE-1:0] w_pc_nxt;
  logic [WORDSIZE-1:0] w_redir_pc_nxt;
  logic                w_squash_nxt;
  logic                w_pending_nxt;
  logic                w_inst_valid_nxt;
  logic [WORDSIZE-1:0] w_inst_out_nxt;
  logic [WORDSIZE-1:0] w_inst_pc_nxt;

  logic [WORDSIZE-1:0] w_pc_inc;
  logic                w_req;
  logic                w_ack;
  logic                w_redirect;
  logic                w_br_misalign;
  logic [WORDSIZE-1:0] w_new_pc;
  logic                w_buf_free;

  pc_sequencer_incpc #(
    .WIDTH (WORDSIZE)
  ) u_incpc (
    .pc     (r_pc),
    .pc_inc (w_pc_inc)
  );

  // The request is withheld for one cycle after a squashed fetch retires so
  // that the redirected address starts a fresh transaction.
  assign w_req = (r_state == c_PCS_FETCH) && !r_pending;

  // Acks outside an active request are meaningless and ignored.
  assign w_ack = w_req && imem_ack;

  assign w_redirect    = trap_req || br_taken;
  assign w_br_misalign = !trap_req && br_taken && is_misaligned(br_target[1:0]);
  assign w_new_pc      = (trap_req || w_br_misalign) ? TRAP_VECTOR : br_target;

  // Buffer can take a new instruction this cycle: empty, or being consumed.
  assign w_buf_free = !r_inst_valid || inst_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_redir_pc_nxt   = r_redir_pc;
    w_squash_nxt     = r_squash;
    w_pending_nxt    = 1'b0;
    w_inst_valid_nxt = r_inst_valid && !inst_ready;
    w_inst_out_nxt   = r_inst_out;
    w_inst_pc_nxt    = r_inst_pc;

    case (r_state)
      c_PCS_RESET: begin
        w_state_nxt = c_PCS_FETCH;
        if (w_redirect) begin
          w_pc_nxt = w_new_pc;
        end
      end

      c_PCS_FETCH: begin
        if (w_redirect) begin
          if (w_req && !imem_ack) begin
            // Address must stay stable until the ack: remember the target
            // and discard whatever the outstanding fetch returns.
            w_redir_pc_nxt = w_new_pc;
            w_squash_nxt   = 1'b1;
          end else begin
            // Either the fetch completes now (its data is dropped) or no
            // request is outstanding; the pc can move immediately.
            w_pc_nxt     = w_new_pc;
            w_squash_nxt = 1'b0;
          end
        end else if (w_ack) begin
          if (r_squash) begin
            w_pc_nxt      = r_redir_pc;
            w_squash_nxt  = 1'b0;
            w_pending_nxt = 1'b1;
          end else if (w_buf_free) begin
            w_inst_out_nxt   = imem_rdata;
            w_inst_pc_nxt    = r_pc;
            w_inst_valid_nxt = 1'b1;
            w_pc_nxt         = w_pc_inc;
          end else begin
            // Decode is stalled with the buffer full: drop the data and keep
            // the pc so the same word is fetched again once decode drains.
            w_state_nxt = c_PCS_HOLD;
          end
        end
      end

      c_PCS_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_new_pc;
          w_state_nxt = c_PCS_FETCH;
        end else if (inst_ready) begin
          w_state_nxt = c_PCS_FETCH;
        end
      end

      default: begin
        w_state_nxt = c_PCS_RESET;
      end
    endcase

    // A redirect always kills the buffered instruction, even if decode
    // would have consumed it this cycle.
    if (w_redirect) begin
      w_inst_valid_nxt = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= c_PCS_RESET;
      r_pc         <= RESET_VECTOR;
      r_redir_pc   <= RESET_VECTOR;
      r_squash     <= 1'b0;
      r_pending    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      r_squash     <= w_squash_nxt;
      r_pending    <= w_pending_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst_out   <= w_inst_out_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_misalign   <= w_br_misalign;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;
  assign misalign   = r_misalign;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Directed stimulus
//               pushes expected (pc, instruction) pairs into a queue; a
//               monitor pops and compares on every decode handshake.
//               Instruction memory returns the bitwise inverse of the address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_req;
  logic        misalign;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   ack_lat  = 0;
  int   wait_cnt = 0;
  logic prev_req = 1'b0;

  pc_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .trap_req   (trap_req),
    .misalign   (misalign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory responder: acks after ack_lat waiting cycles of a held request.
  always @(negedge CLK) begin
    if (!imem_req) begin
      wait_cnt = 0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack || !prev_req) wait_cnt = 0;
      else                       wait_cnt = wait_cnt + 1;
      imem_ack   = (wait_cnt >= ack_lat);
      imem_rdata = ~imem_addr;
    end
    prev_req = imem_req;
  end

  // Monitor: every instruction decode accepts must match the queue head.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst: got pc %h data %h, required no instruction", inst_pc, inst_out);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst_out !== e.data) begin
          errors++;
          $display("FAIL inst_stream: got pc %h data %h, required pc %h data %h",
                   inst_pc, inst_out, e.pc, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int lat);
    RST      = 1'b1;
    br_taken = 1'b0;
    trap_req = 1'b0;
    step();
    ack_lat = lat;
    step();
    chk("rst_req",      {31'd0, imem_req},   32'd0);
    chk("rst_valid",    {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_out", inst_out,            32'd0);
    chk("rst_inst_pc",  inst_pc,             32'd0);
    chk("rst_misalign", {31'd0, misalign},   32'd0);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    RST        = 1'b1;
    inst_ready = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    trap_req   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    // ---- Back-to-back fetch, then decode stall and resume -----------------
    do_reset(0);
    step();
    chk("s1_req",   {31'd0, imem_req}, 32'd1);
    chk("s1_addr0", imem_addr, 32'h0);
    step();
    chk("s1_addr4",  imem_addr, 32'h4);
    chk("s1_valid",  {31'd0, inst_valid}, 32'd1);
    chk("s1_ipc0",   inst_pc, 32'h0);
    push(32'h0, 32'hFFFF_FFFF);
    step();
    chk("s1_addr8", imem_addr, 32'h8);
    push(32'h4, 32'hFFFF_FFFB);
    step();
    chk("s1_addrC", imem_addr, 32'hC);
    push(32'h8, 32'hFFFF_FFF7);
    step();
    inst_ready = 1'b0;
    step();
    chk("s1_hold_req", {31'd0, imem_req}, 32'd0);
    chk("s1_hold_ipc", inst_pc, 32'hC);
    chk("s1_hold_out", inst_out, 32'hFFFF_FFF3);
    step();
    step();
    chk("s1_stable_out", inst_out, 32'hFFFF_FFF3);
    chk("s1_stable_req", {31'd0, imem_req}, 32'd0);
    push(32'hC, 32'hFFFF_FFF3);
    inst_ready = 1'b1;
    step();
    chk("s1_resume_req",  {31'd0, imem_req}, 32'd1);
    chk("s1_resume_addr", imem_addr, 32'h10);
    chk("s1_resume_vld",  {31'd0, inst_valid}, 32'd0);

    // ---- Late ack with branch in the wait window, then reset mid-fetch ----
    do_reset(3);
    step();
    chk("s3_addr0", imem_addr, 32'h0);
    br_taken  = 1'b1;
    br_target = 32'h40;
    step();
    br_taken = 1'b0;
    chk("s3_wait1_addr", imem_addr, 32'h0);
    chk("s3_wait1_req",  {31'd0, imem_req}, 32'd1);
    step();
    chk("s3_wait2_addr", imem_addr, 32'h0);
    step();
    chk("s3_wait3_addr", imem_addr, 32'h0);
    step();
    chk("s3_gap_req",   {31'd0, imem_req}, 32'd0);
    chk("s3_gap_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("s3_redir_req",  {31'd0, imem_req}, 32'd1);
    chk("s3_redir_addr", imem_addr, 32'h40);
    push(32'h40, 32'hFFFF_FFBF);
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_q.size() == 0) break;
    end
    chk("s3_drained", exp_q.size(), 32'd0);
    chk("s3_next_req",  {31'd0, imem_req}, 32'd1);
    chk("s3_next_addr", imem_addr, 32'h44);
    RST = 1'b1;
    step();
    chk("s6_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("s6_rst_valid", {31'd0, inst_valid}, 32'd0);
    RST = 1'b0;
    step();
    chk("s6_refetch_req",  {31'd0, imem_req}, 32'd1);
    chk("s6_refetch_addr", imem_addr, 32'h0);

    // ---- Misaligned branch, trap priority, address wrap -------------------
    do_reset(0);
    step();
    br_taken  = 1'b1;
    br_target = 32'h42;
    step();
    br_taken = 1'b0;
    chk("s4_misalign",   {31'd0, misalign}, 32'd1);
    chk("s4_trap_addr",  imem_addr, 32'h100);
    chk("s4_kill_valid", {31'd0, inst_valid}, 32'd0);
    push(32'h100, 32'hFFFF_FEFF);
    step();
    chk("s4_misalign_off", {31'd0, misalign}, 32'd0);
    chk("s4_ipc100",       inst_pc, 32'h100);
    trap_req  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h82;
    step();
    trap_req = 1'b0;
    br_taken = 1'b0;
    chk("s4_trapbr_addr", imem_addr, 32'h100);
    chk("s4_trapbr_mis",  {31'd0, misalign}, 32'd0);
    chk("s4_trapbr_vld",  {31'd0, inst_valid}, 32'd0);
    push(32'h100, 32'hFFFF_FEFF);
    step();
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    chk("s5_top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("s5_wrap_addr", imem_addr, 32'h0);
    chk("s5_wrap_req",  {31'd0, imem_req}, 32'd1);
    chk("s5_top_ipc",   inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b0;
    step();
    chk("s5_hold_req", {31'd0, imem_req}, 32'd0);
    chk("s5_hold_out", inst_out, 32'h0000_0003);
    chk("s5_hold_ipc", inst_pc, 32'hFFFF_FFFC);
    chk("s5_drained",  exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
